alu_pipe: RTL and testbench
===========================

# alu_pipe

Parametrised, pipelined successor to the single-cycle ALU. It accepts operands that may arrive in separate cycles, with optional timeout, and handles both logical and arithmetic command sets. Multiply commands run through a 3-stage path; all other commands complete in one cycle. Each result is marked with a one-cycle `res_valid` pulse. The block sits between the stimulus/driver interface and the result monitor, and replaces the fixed-width ALU in new subsystems.

## Interface
- `WIDTH`, 8: operand width in bits.
- `CWIDTH`, 4: command field width in bits.
- `TIMEOUT`, 16: maximum number of `ce`-enabled cycles to wait for a missing operand.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset; asynchronous assert, active-low (0 = reset), synchronous release.
- `ce`  in  1  clock enable; 0 freezes all state and outputs.
- `inp_valid`  in  2  bit0 = `opa` valid, bit1 = `opb` valid.
- `mode`  in  1  1 = arithmetic, 0 = logical.
- `cmd`  in  `CWIDTH`  operation code.
- `opa`, `opb`  in  `WIDTH`  unsigned operands.
- `cin`  in  1  carry-in.
- `res`  out  2*`WIDTH`  result, zero-extended except for multiply.
- `res_valid`  out  1  one-cycle pulse; `res` and flags are valid.
- `busy`  out  1  multiply in flight; inputs are ignored.
- `err`  out  1  illegal command, bad rotate amount, or timeout.
- `cout`, `oflow`  out  1  carry / borrow.
- `g`, `l`, `e`  out  1  compare flags, `opa` vs `opb`.

## Operation
- **Arithmetic commands (`mode`=1):**
  - 0 ADD, 1 SUB, 2 ADD+`cin`, 3 SUB−`cin`.
  - 4 INC_A, 5 DEC_A, 6 INC_B, 7 DEC_B.
  - 8 CMP.
  - 9 MUL_INC = (`opa`+1)×(`opb`+1).
  - 10 MUL_SHL = (`opa`<<1 mod 2^`WIDTH`)×`opb`.
- **Logical commands (`mode`=0):**
  - 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR.
  - 6 NOT_A, 7 NOT_B.
  - 8 SHR1_A, 9 SHL1_A, 10 SHR1_B, 11 SHL1_B.
  - 12 ROL_A_B, 13 ROR_A_B.
- **Single-operand commands:** INC_A, DEC_A, NOT_A, SHR1_A and SHL1_A need only `opa`. INC_B, DEC_B, NOT_B, SHR1_B and SHL1_B need only `opb`. All other commands need both.
- **States:**
  - IDLE → ISSUE when the required operands are valid in the same cycle.
  - IDLE → WAIT_B on `inp_valid`=01 for a two-operand command; WAIT_A on 10, likewise.
  - WAIT_x → ISSUE when the missing operand arrives; any `inp_valid` with the missing bit set completes it.
  - WAIT_x → IDLE with `err` on timeout.
  - ISSUE → MUL1 → MUL2 for multiply commands.
- **Latching rules:** `cmd`, `mode` and `cin` are latched at the first operand; values presented on later cycles are ignored. A re-presented operand overwrites the latched copy.
- **Flags:**
  - ADD / ADD+`cin` / INC: `cout` = bit `WIDTH` of the sum.
  - SUB / SUB−`cin` / DEC: `oflow` = borrow, i.e. `opa` < `opb`(+`cin`).
  - CMP: `res`=0, exactly one of `g`/`l`/`e` is 1.
  - All flags not defined for a command are 0.
- **Rotate:** amount is `opb`[log2(`WIDTH`)−1:0]. Any higher `opb` bit set → `err`=1, `res`=0.
- **Illegal `cmd`:** `err`=1, `res`=0, `res_valid`=1, one-cycle latency.
- **Width:** non-multiply results are `WIDTH`+1 bits, zero-extended to 2*`WIDTH`. Multiply results use the full 2*`WIDTH`. All arithmetic wraps modulo the result width.

## Timing
- **Reset:** all outputs 0 and state IDLE while `rst`=0; in-flight operations are discarded.
- **Single-cycle commands:** operands complete at edge T → `res_valid`=1 in cycle T+1 only.
- **Multiply:** `res_valid` in cycle T+3. `busy`=1 in cycles T+1 and T+2, and `inp_valid` is dropped silently during those cycles. New operands are accepted again from cycle T+3.
- **Back-to-back:** single-cycle commands issue at one per cycle; the next operation may complete in the same cycle as a `res_valid` pulse.
- **Timeout:** the counter runs only while `ce`=1 and resets on entry to WAIT_x. At count `TIMEOUT` the block returns `err`=1, `res_valid`=1, `res`=0, then goes to IDLE.
- **`ce`=0:** all state, outputs, the counter and the multiply stages hold; a `res_valid` pulse is extended for the duration.
- **Reset mid-multiply:** the result is never produced.

## Configuration
- `ALU_TIMEOUT_EN` defined: WAIT_x states time out as described under Timing.
- `ALU_TIMEOUT_EN` undefined: no counter; WAIT_x persists until the missing operand arrives or reset. `TIMEOUT` is ignored.

## Test plan
- `WIDTH`=8, `mode`=1, `cmd`=0, `opa`=0xFF, `opb`=0x01, `inp_valid`=11 → next cycle `res`=0x100, `cout`=1, `res_valid`=1.
- `cmd`=9 (MUL_INC), `opa`=3, `opb`=4 → `busy` for 2 cycles, `res`=20 at T+3; `inp_valid`=11 presented during `busy` yields no result.
- `mode`=0, `cmd`=4 (XOR): `inp_valid`=01 with `opa`=0xF0, 3 idle cycles, then 10 with `opb`=0x3C → `res`=0xCC one cycle later.
- `ALU_TIMEOUT_EN` defined, `TIMEOUT`=16: `inp_valid`=01 for ADD, no `opb` → `err`=1, `res_valid`=1 on the 16th enabled cycle; toggling `ce` low for 5 cycles delays it by 5.
- ROL_A_B with `opb`=0x10, `WIDTH`=8 → `err`=1, `res`=0. CMP 5 vs 9 → `l`=1, `g`=0, `e`=0.
- Assert `rst`=0 in cycle T+1 of a multiply → all outputs 0 immediately, no `res_valid` after release.

Source files
------------

// File: rtl/alu_pipe.sv
// alu_pipe: pipelined ALU with split operand capture and a 3-stage multiply.
// Define ALU_TIMEOUT_EN to make the WAIT_A/WAIT_B states time out.
module alu_pipe #(
  parameter int WIDTH   = 8,
  parameter int CWIDTH  = 4,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic [1:0]        inp_valid,
  input  logic              mode,
  input  logic [CWIDTH-1:0] cmd,
  input  logic [WIDTH-1:0]  opa,
  input  logic [WIDTH-1:0]  opb,
  input  logic              cin,
  output logic [2*WIDTH-1:0] res,
  output logic              res_valid,
  output logic              busy,
  output logic              err,
  output logic              cout,
  output logic              oflow,
  output logic              g,
  output logic              l,
  output logic              e
);

  localparam int RW = 2 * WIDTH;
  localparam int SW = $clog2(WIDTH);
  localparam logic [WIDTH:0] ONE = (WIDTH + 1)'(1);
  localparam logic [RW-1:0] RONE = RW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_A,
    S_WAIT_B,
    S_MUL1,
    S_MUL2
  } state_t;

  state_t state, state_n;

  logic [CWIDTH-1:0] l_cmd;
  logic              l_mode;
  logic              l_cin;
  logic [WIDTH-1:0]  l_a;
  logic [WIDTH-1:0]  l_b;
  logic [RW-1:0]     m_x;
  logic [RW-1:0]     m_y;
  logic [RW-1:0]     m_p;

  logic              idle;
  logic              waiting;
  logic              open;
  logic [CWIDTH-1:0] c_cmd;
  logic              c_mode;
  logic              c_cin;
  logic [WIDTH-1:0]  c_a;
  logic [WIDTH-1:0]  c_b;
  logic              na;
  logic              nb;
  logic              have_a;
  logic              have_b;
  logic              complete;
  logic              tmo;

  logic [WIDTH:0]    ea;
  logic [WIDTH:0]    eb;
  logic [WIDTH:0]    ecin;
  logic [WIDTH:0]    t;
  logic [WIDTH-1:0]  lo;
  logic [SW-1:0]     amt;
  logic              bhi;
  logic [RW-1:0]     r;
  logic              f_cout;
  logic              f_oflow;
  logic              f_g;
  logic              f_l;
  logic              f_e;
  logic              f_err;
  logic              f_mul;
  logic [RW-1:0]     mx;
  logic [RW-1:0]     my;

  assign idle    = (state == S_IDLE);
  assign waiting = (state == S_WAIT_A) || (state == S_WAIT_B);
  assign open    = idle || waiting;
  assign busy    = (state == S_MUL1) || (state == S_MUL2);

  // cmd/mode/cin come live only with the first operand; later cycles use the latch
  assign c_cmd  = idle ? cmd  : l_cmd;
  assign c_mode = idle ? mode : l_mode;
  assign c_cin  = idle ? cin  : l_cin;
  assign c_a    = inp_valid[0] ? opa : l_a;
  assign c_b    = inp_valid[1] ? opb : l_b;
  assign have_a = inp_valid[0] || (state == S_WAIT_B);
  assign have_b = inp_valid[1] || (state == S_WAIT_A);

  always_comb begin
    na = 1'b1;
    nb = 1'b1;
    if (c_mode) begin
      if (c_cmd == CWIDTH'(4) || c_cmd == CWIDTH'(5)) nb = 1'b0;
      if (c_cmd == CWIDTH'(6) || c_cmd == CWIDTH'(7)) na = 1'b0;
    end else begin
      if (c_cmd == CWIDTH'(6) || c_cmd == CWIDTH'(8) ||
          c_cmd == CWIDTH'(9)) nb = 1'b0;
      if (c_cmd == CWIDTH'(7) || c_cmd == CWIDTH'(10) ||
          c_cmd == CWIDTH'(11)) na = 1'b0;
    end
  end

  assign complete = open && (|inp_valid) &&
                    (!na || have_a) && (!nb || have_b);

  always_comb begin
    ea      = {1'b0, c_a};
    eb      = {1'b0, c_b};
    ecin    = {{WIDTH{1'b0}}, c_cin};
    t       = '0;
    lo      = '0;
    r       = '0;
    amt     = c_b[SW-1:0];
    bhi     = (c_b >> SW) != '0;
    f_cout  = 1'b0;
    f_oflow = 1'b0;
    f_g     = 1'b0;
    f_l     = 1'b0;
    f_e     = 1'b0;
    f_err   = 1'b0;
    f_mul   = 1'b0;
    mx      = '0;
    my      = '0;
    if (c_mode) begin
      case (int'(c_cmd))
        0: begin t = ea + eb; f_cout = t[WIDTH]; end
        1: begin t = ea - eb; f_oflow = t[WIDTH]; end
        2: begin t = ea + eb + ecin; f_cout = t[WIDTH]; end
        3: begin t = ea - eb - ecin; f_oflow = t[WIDTH]; end
        4: begin t = ea + ONE; f_cout = t[WIDTH]; end
        5: begin t = ea - ONE; f_oflow = t[WIDTH]; end
        6: begin t = eb + ONE; f_cout = t[WIDTH]; end
        7: begin t = eb - ONE; f_oflow = t[WIDTH]; end
        8: begin
          f_g = c_a > c_b;
          f_l = c_a < c_b;
          f_e = c_a == c_b;
        end
        9: begin
          f_mul = 1'b1;
          mx = RW'(c_a) + RONE;
          my = RW'(c_b) + RONE;
        end
        10: begin
          f_mul = 1'b1;
          mx = RW'({c_a[WIDTH-2:0], 1'b0});
          my = RW'(c_b);
        end
        default: f_err = 1'b1;
      endcase
      r = RW'(t);
    end else begin
      case (int'(c_cmd))
        0:  lo = c_a & c_b;
        1:  lo = ~(c_a & c_b);
        2:  lo = c_a | c_b;
        3:  lo = ~(c_a | c_b);
        4:  lo = c_a ^ c_b;
        5:  lo = ~(c_a ^ c_b);
        6:  lo = ~c_a;
        7:  lo = ~c_b;
        8:  lo = c_a >> 1;
        9:  lo = c_a << 1;
        10: lo = c_b >> 1;
        11: lo = c_b << 1;
        12: begin
          if (bhi) f_err = 1'b1;
          else lo = (c_a << amt) | (c_a >> (WIDTH - int'(amt)));
        end
        13: begin
          if (bhi) f_err = 1'b1;
          else lo = (c_a >> amt) | (c_a << (WIDTH - int'(amt)));
        end
        default: f_err = 1'b1;
      endcase
      r = RW'(lo);
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE, S_WAIT_A, S_WAIT_B: begin
        if (complete) state_n = f_mul ? S_MUL1 : S_IDLE;
        else if (tmo) state_n = S_IDLE;
        else if (idle && (|inp_valid))
          state_n = (na && !have_a) ? S_WAIT_A : S_WAIT_B;
      end
      S_MUL1: state_n = S_MUL2;
      S_MUL2: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

`ifdef ALU_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT + 1);
  logic [TCW-1:0] tcnt;

  assign tmo = waiting && !complete && (tcnt == TCW'(TIMEOUT - 1));

  // held at zero in IDLE so every WAIT entry starts a fresh count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tcnt <= '0;
    else if (ce) begin
      if (waiting) tcnt <= tcnt + TCW'(1);
      else tcnt <= '0;
    end
  end
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      l_cmd     <= '0;
      l_mode    <= 1'b0;
      l_cin     <= 1'b0;
      l_a       <= '0;
      l_b       <= '0;
      m_x       <= '0;
      m_y       <= '0;
      m_p       <= '0;
      res       <= '0;
      res_valid <= 1'b0;
      err       <= 1'b0;
      cout      <= 1'b0;
      oflow     <= 1'b0;
      g         <= 1'b0;
      l         <= 1'b0;
      e         <= 1'b0;
    end else if (ce) begin
      state     <= state_n;
      res       <= '0;
      res_valid <= 1'b0;
      err       <= 1'b0;
      cout      <= 1'b0;
      oflow     <= 1'b0;
      g         <= 1'b0;
      l         <= 1'b0;
      e         <= 1'b0;
      if (idle && (|inp_valid)) begin
        l_cmd  <= cmd;
        l_mode <= mode;
        l_cin  <= cin;
      end
      if (open && inp_valid[0]) l_a <= opa;
      if (open && inp_valid[1]) l_b <= opb;
      if (complete && f_mul) begin
        m_x <= mx;
        m_y <= my;
      end
      if (complete && !f_mul) begin
        res       <= r;
        res_valid <= 1'b1;
        err       <= f_err;
        cout      <= f_cout;
        oflow     <= f_oflow;
        g         <= f_g;
        l         <= f_l;
        e         <= f_e;
      end
      if (tmo) begin
        res_valid <= 1'b1;
        err       <= 1'b1;
      end
      if (state == S_MUL1) m_p <= m_x * m_y;
      if (state == S_MUL2) begin
        res       <= m_p;
        res_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: vector table, hand sequences and randomized ops vs a reference model.
// Timeout sequence runs when ALU_TIMEOUT_EN is defined, persistence check otherwise.
module tb_alu_pipe;

  localparam int W   = 8;
  localparam int TMO = 16;

  logic        clk;
  logic        rst;
  logic        ce;
  logic [1:0]  inp_valid;
  logic        mode;
  logic [3:0]  cmd;
  logic [7:0]  opa;
  logic [7:0]  opb;
  logic        cin;
  logic [15:0] res;
  logic        res_valid;
  logic        busy;
  logic        err;
  logic        cout;
  logic        oflow;
  logic        g;
  logic        l;
  logic        e;

  int n_run  = 0;
  int n_fail = 0;

  alu_pipe #(.WIDTH(W), .CWIDTH(4), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .ce(ce), .inp_valid(inp_valid),
    .mode(mode), .cmd(cmd), .opa(opa), .opb(opb), .cin(cin),
    .res(res), .res_valid(res_valid), .busy(busy), .err(err),
    .cout(cout), .oflow(oflow), .g(g), .l(l), .e(e)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int res;
    bit err;
    bit cout;
    bit oflow;
    bit g;
    bit l;
    bit e;
    bit mul;
  } exp_t;

  typedef struct {
    bit   m;
    int   c;
    int   a;
    int   b;
    bit   ci;
    exp_t x;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_run++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // which operands a command consumes: bit0 = opa, bit1 = opb
  function automatic int need(input bit m, input int c);
    if (m) begin
      if (c == 4 || c == 5) return 1;
      if (c == 6 || c == 7) return 2;
    end else begin
      if (c == 6 || c == 8 || c == 9) return 1;
      if (c == 7 || c == 10 || c == 11) return 2;
    end
    return 3;
  endfunction

  function automatic int rol8(input int a, input int n);
    return ((a * (2 ** n)) % 256) + (a / (2 ** (8 - n)));
  endfunction

  function automatic exp_t model(input bit m, input int c, input int a,
                                 input int b, input bit ci);
    exp_t x;
    x = '{default: 0};
    if (m) begin
      case (c)
        0: begin x.res = (a + b) % 512; x.cout = (a + b) > 255; end
        1: begin x.res = (a - b + 512) % 512; x.oflow = a < b; end
        2: begin x.res = (a + b + ci) % 512; x.cout = (a + b + ci) > 255; end
        3: begin x.res = (a - b - ci + 512) % 512; x.oflow = a < b + ci; end
        4: begin x.res = a + 1; x.cout = a == 255; end
        5: begin x.res = (a + 511) % 512; x.oflow = a == 0; end
        6: begin x.res = b + 1; x.cout = b == 255; end
        7: begin x.res = (b + 511) % 512; x.oflow = b == 0; end
        8: begin x.g = a > b; x.l = a < b; x.e = a == b; end
        9: begin x.mul = 1; x.res = ((a + 1) * (b + 1)) % 65536; end
        10: begin x.mul = 1; x.res = (((a * 2) % 256) * b) % 65536; end
        default: x.err = 1;
      endcase
    end else begin
      case (c)
        0: x.res = a & b;
        1: x.res = 255 - (a & b);
        2: x.res = a | b;
        3: x.res = 255 - (a | b);
        4: x.res = a ^ b;
        5: x.res = 255 - (a ^ b);
        6: x.res = 255 - a;
        7: x.res = 255 - b;
        8: x.res = a / 2;
        9: x.res = (a * 2) % 256;
        10: x.res = b / 2;
        11: x.res = (b * 2) % 256;
        12: if (b > 7) x.err = 1; else x.res = rol8(a, b);
        13: if (b > 7) x.err = 1; else x.res = rol8(a, (8 - b) % 8);
        default: x.err = 1;
      endcase
    end
    return x;
  endfunction

  // called right after the completing edge; junk is offered during busy
  task automatic finish_check(input string nm, input exp_t x);
    if (x.mul) begin
      chk({nm, "_busy1"}, int'({busy, res_valid}), 2);
      inp_valid = 2'b11;
      mode = 1'b1;
      cmd = 4'd0;
      tick();
      chk({nm, "_busy2"}, int'({busy, res_valid}), 2);
      tick();
    end
    inp_valid = 2'b00;
    chk({nm, "_valid"}, int'({busy, res_valid}), 1);
    chk({nm, "_res"}, int'(res), x.res);
    chk({nm, "_flags"}, int'({err, cout, oflow, g, l, e}),
        int'({x.err, x.cout, x.oflow, x.g, x.l, x.e}));
  endtask

  task automatic issue(input bit m, input int c, input int a, input int b,
                       input bit ci, input logic [1:0] iv);
    mode = m;
    cmd = 4'(c);
    opa = 8'(a);
    opb = 8'(b);
    cin = ci;
    inp_valid = iv;
    tick();
  endtask

  vec_t tbl[$];

  initial begin
    rst = 1'b0;
    ce = 1'b1;
    inp_valid = 2'b00;
    mode = 1'b0;
    cmd = 4'd0;
    opa = 8'd0;
    opb = 8'd0;
    cin = 1'b0;

    tbl.push_back('{1, 0, 'hFF, 'h01, 0, '{'h100, 0, 1, 0, 0, 0, 0, 0}});
    tbl.push_back('{1, 1, 'h01, 'h02, 0, '{'h1FF, 0, 0, 1, 0, 0, 0, 0}});
    tbl.push_back('{1, 2, 'h80, 'h7F, 1, '{'h100, 0, 1, 0, 0, 0, 0, 0}});
    tbl.push_back('{1, 3, 'h05, 'h05, 1, '{'h1FF, 0, 0, 1, 0, 0, 0, 0}});
    tbl.push_back('{1, 4, 'hFF, 'h00, 0, '{'h100, 0, 1, 0, 0, 0, 0, 0}});
    tbl.push_back('{1, 5, 'h00, 'h00, 0, '{'h1FF, 0, 0, 1, 0, 0, 0, 0}});
    tbl.push_back('{1, 6, 'h00, 'h10, 0, '{'h11, 0, 0, 0, 0, 0, 0, 0}});
    tbl.push_back('{1, 7, 'h00, 'h10, 0, '{'h0F, 0, 0, 0, 0, 0, 0, 0}});
    tbl.push_back('{1, 8, 'h05, 'h09, 0, '{'h00, 0, 0, 0, 0, 1, 0, 0}});
    tbl.push_back('{1, 8, 'h09, 'h09, 0, '{'h00, 0, 0, 0, 0, 0, 1, 0}});
    tbl.push_back('{1, 8, 'h09, 'h05, 0, '{'h00, 0, 0, 0, 1, 0, 0, 0}});
    tbl.push_back('{1, 11, 'h09, 'h05, 0, '{'h00, 1, 0, 0, 0, 0, 0, 0}});
    tbl.push_back('{0, 0, 'hF0, 'h3C, 0, '{'h30, 0, 0, 0, 0, 0, 0, 0}});
    tbl.push_back('{0, 1, 'hF0, 'h3C, 0, '{'hCF, 0, 0, 0, 0, 0, 0, 0}});
    tbl.push_back('{0, 2, 'hF0, 'h3C, 0, '{'hFC, 0, 0, 0, 0, 0, 0, 0}});
    tbl.push_back('{0, 3, 'hF0, 'h3C, 0, '{'h03, 0, 0, 0, 0, 0, 0, 0}});
    tbl.push_back('{0, 4, 'hF0, 'h3C, 0, '{'hCC, 0, 0, 0, 0, 0, 0, 0}});
    tbl.push_back('{0, 5, 'hF0, 'h3C, 0, '{'h33, 0, 0, 0, 0, 0, 0, 0}});
    tbl.push_back('{0, 6, 'hF0, 'h3C, 0, '{'h0F, 0, 0, 0, 0, 0, 0, 0}});
    tbl.push_back('{0, 7, 'hF0, 'h3C, 0, '{'hC3, 0, 0, 0, 0, 0, 0, 0}});
    tbl.push_back('{0, 8, 'hF0, 'h3C, 0, '{'h78, 0, 0, 0, 0, 0, 0, 0}});
    tbl.push_back('{0, 9, 'hF0, 'h3C, 0, '{'hE0, 0, 0, 0, 0, 0, 0, 0}});
    tbl.push_back('{0, 10, 'hF0, 'h3C, 0, '{'h1E, 0, 0, 0, 0, 0, 0, 0}});
    tbl.push_back('{0, 11, 'hF0, 'h3C, 0, '{'h78, 0, 0, 0, 0, 0, 0, 0}});
    tbl.push_back('{0, 12, 'h81, 'h01, 0, '{'h03, 0, 0, 0, 0, 0, 0, 0}});
    tbl.push_back('{0, 13, 'h81, 'h01, 0, '{'hC0, 0, 0, 0, 0, 0, 0, 0}});
    tbl.push_back('{0, 12, 'h81, 'h10, 0, '{'h00, 1, 0, 0, 0, 0, 0, 0}});
    tbl.push_back('{0, 14, 'h81, 'h01, 0, '{'h00, 1, 0, 0, 0, 0, 0, 0}});
    tbl.push_back('{1, 9, 3, 4, 0, '{20, 0, 0, 0, 0, 0, 0, 1}});
    tbl.push_back('{1, 10, 'h81, 3, 0, '{6, 0, 0, 0, 0, 0, 0, 1}});

    tick();
    tick();
    chk("reset_outs", int'({res, res_valid, busy, err, cout, oflow, g, l, e}), 0);
    rst = 1'b1;
    tick();
    chk("post_reset_idle", int'({res_valid, busy}), 0);

    foreach (tbl[i]) begin
      issue(tbl[i].m, tbl[i].c, tbl[i].a, tbl[i].b, tbl[i].ci, 2'b11);
      finish_check($sformatf("vec%0d", i), tbl[i].x);
    end
    tick();
    chk("idle_after_vec", int'(res_valid), 0);

    // split XOR: opa, three idle cycles, then opb
    issue(0, 4, 'hF0, 'h00, 0, 2'b01);
    inp_valid = 2'b00;
    chk("split_wait0", int'(res_valid), 0);
    repeat (3) tick();
    chk("split_wait3", int'(res_valid), 0);
    issue(1, 0, 'h00, 'h3C, 1, 2'b10);
    finish_check("split_xor", model(0, 4, 'hF0, 'h3C, 0));

    // back-to-back single-cycle ops
    issue(1, 0, 1, 2, 0, 2'b11);
    mode = 1'b0;
    cmd = 4'd4;
    opa = 8'hF0;
    opb = 8'h3C;
    chk("b2b_first", int'({res_valid, res}), int'({1'b1, 16'd3}));
    tick();
    inp_valid = 2'b00;
    chk("b2b_second", int'({res_valid, res}), int'({1'b1, 16'hCC}));
    tick();
    chk("b2b_done", int'(res_valid), 0);

    // ce low holds the pulse and ignores inputs
    issue(1, 0, 'hFF, 'h01, 0, 2'b11);
    ce = 1'b0;
    mode = 1'b0;
    cmd = 4'd0;
    repeat (3) tick();
    chk("ce_hold", int'({res_valid, res, cout}), int'({1'b1, 16'h100, 1'b1}));
    ce = 1'b1;
    inp_valid = 2'b00;
    tick();
    chk("ce_release", int'(res_valid), 0);

    // reset in cycle T+1 of a multiply
    issue(1, 9, 3, 4, 0, 2'b11);
    inp_valid = 2'b00;
    chk("rst_mul_busy", int'(busy), 1);
    rst = 1'b0;
    #1;
    chk("rst_mul_async", int'({res, res_valid, busy, err}), 0);
    tick();
    rst = 1'b1;
    begin
      int seen;
      seen = 0;
      repeat (5) begin
        tick();
        if (res_valid) seen++;
      end
      chk("rst_mul_no_result", seen, 0);
    end

`ifdef ALU_TIMEOUT_EN
    begin
      int seen;
      seen = 0;
      issue(1, 0, 'h11, 0, 0, 2'b01);
      inp_valid = 2'b00;
      repeat (15) begin
        tick();
        if (res_valid) seen++;
      end
      chk("tmo_early", seen, 0);
      tick();
      chk("tmo_fire", int'({res_valid, err, res}), int'({2'b11, 16'h0}));
      tick();
      chk("tmo_idle", int'(res_valid), 0);
      issue(1, 0, 'h11, 0, 0, 2'b01);
      inp_valid = 2'b00;
      repeat (8) tick();
      ce = 1'b0;
      repeat (5) tick();
      ce = 1'b1;
      repeat (7) tick();
      chk("tmo_ce_early", int'(res_valid), 0);
      tick();
      chk("tmo_ce_fire", int'({res_valid, err}), 3);
      tick();
    end
`else
    begin
      int seen;
      seen = 0;
      issue(1, 0, 'h11, 0, 0, 2'b01);
      inp_valid = 2'b00;
      repeat (40) begin
        tick();
        if (res_valid) seen++;
      end
      chk("wait_persists", seen, 0);
      issue(0, 0, 0, 'h22, 0, 2'b10);
      finish_check("wait_late_b", model(1, 0, 'h11, 'h22, 0));
    end
`endif

    for (int i = 0; i < 400; i++) begin
      bit   m;
      bit   ci;
      bit   fa;
      int   c;
      int   a;
      int   b;
      int   nd;
      int   k;
      int   seen;
      exp_t x;
      m = 1'($urandom_range(0, 1));
      c = $urandom_range(0, 15);
      a = $urandom_range(0, 255);
      b = $urandom_range(0, 255);
      ci = 1'($urandom_range(0, 1));
      if (!m && c >= 12 && $urandom_range(0, 3) != 0) b = b % 8;
      nd = need(m, c);
      if (nd == 3 && $urandom_range(0, 2) == 0) begin
        fa = 1'($urandom_range(0, 1));
        issue(m, c, a, b, ci, fa ? 2'b01 : 2'b10);
        seen = res_valid ? 1 : 0;
        k = $urandom_range(0, 4);
        repeat (k) begin
          mode = 1'($urandom_range(0, 1));
          cmd = 4'($urandom_range(0, 15));
          cin = 1'($urandom_range(0, 1));
          inp_valid = 2'b00;
          if ($urandom_range(0, 2) == 0) begin
            if (fa) a = $urandom_range(0, 255);
            else b = $urandom_range(0, 255);
            opa = 8'(a);
            opb = 8'(b);
            inp_valid = fa ? 2'b01 : 2'b10;
          end
          tick();
          if (res_valid) seen++;
        end
        chk($sformatf("rnd%0d_wait", i), seen, 0);
        mode = 1'($urandom_range(0, 1));
        cmd = 4'($urandom_range(0, 15));
        cin = 1'($urandom_range(0, 1));
        opa = fa ? 8'($urandom_range(0, 255)) : 8'(a);
        opb = fa ? 8'(b) : 8'($urandom_range(0, 255));
        inp_valid = fa ? 2'b10 : 2'b01;
        tick();
      end else begin
        issue(m, c, a, b, ci, ($urandom_range(0, 1) != 0) ? 2'b11 : 2'(nd));
      end
      x = model(m, c, a, b, ci);
      finish_check($sformatf("rnd%0d", i), x);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
